// File: rtl/datapath_regfile.sv
// rtl/datapath_regfile.sv - 32x32 register file, R0 zero, load-pending scoreboard with stall
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module datapath_regfile #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int CW   = $clog2(NREG + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] D_data,
  input  logic [AW-1:0] DA,
  input  logic          RW,
  input  logic [AW-1:0] AA,
  input  logic [AW-1:0] BA,
  output logic [DW-1:0] A_data,
  output logic [DW-1:0] B_data,
  input  logic          ld_issue,
  input  logic [AW-1:0] ld_dest,
  input  logic          ld_done,
  output logic          stall,
  output logic [CW-1:0] pend_cnt
);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [CW-1:0]   pend_cnt_q;
  logic [CW-1:0]   pend_cnt_d;

  logic wr_en;
  logic a_hit, b_hit;
  logic a_mask, b_mask;

  assign wr_en = RW && (DA != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[DA] = D_data;
    end
  end

  // Clear is applied before set so a re-issued load to the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_en && ld_done) begin
      pend_d[DA] = 1'b0;
    end
    if (ld_issue && (ld_dest != '0)) begin
      pend_d[ld_dest] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_cnt_d = pend_cnt_d + CW'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '{default: '0};
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // rst_n gates forwarding so reads stay zero while reset is held.
  assign a_hit  = rst_n && wr_en && (DA == AA);
  assign b_hit  = rst_n && wr_en && (DA == BA);
  assign a_mask = a_hit && ld_done;
  assign b_mask = b_hit && ld_done;
`else
  assign a_hit  = 1'b0;
  assign b_hit  = 1'b0;
  assign a_mask = 1'b0;
  assign b_mask = 1'b0;
`endif

  assign A_data   = a_hit ? D_data : regs_q[AA];
  assign B_data   = b_hit ? D_data : regs_q[BA];
  assign stall    = (pend_q[AA] && (AA != '0) && !a_mask) ||
                    (pend_q[BA] && (BA != '0) && !b_mask);
  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_datapath_regfile.sv
// tb/tb_datapath_regfile.sv - scoreboard bench for datapath_regfile (honours REGFILE_BYPASS_EN)
module tb_datapath_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] D_data;
  logic [4:0]  DA, AA, BA, ld_dest;
  logic        RW, ld_issue, ld_done;
  logic [31:0] A_data, B_data;
  logic        stall;
  logic [5:0]  pend_cnt;

  datapath_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D_data   (D_data),
    .DA       (DA),
    .RW       (RW),
    .AA       (AA),
    .BA       (BA),
    .A_data   (A_data),
    .B_data   (B_data),
    .ld_issue (ld_issue),
    .ld_dest  (ld_dest),
    .ld_done  (ld_done),
    .stall    (stall),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic        st;
    logic [5:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale expectation due=%0d now=%0d", e.name, e.cyc, cyc);
      end else begin
        chk({e.name, ".A_data"},   A_data,          e.a);
        chk({e.name, ".B_data"},   B_data,          e.b);
        chk({e.name, ".stall"},    {31'b0, stall},  {31'b0, e.st});
        chk({e.name, ".pend_cnt"}, {26'b0, pend_cnt}, {26'b0, e.cnt});
      end
    end
  end

  task automatic expect_out(input string n, input logic [31:0] a, input logic [31:0] b,
                            input logic st, input logic [5:0] c);
    exp_t x;
    x.name = n; x.cyc = cyc; x.a = a; x.b = b; x.st = st; x.cnt = c;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RW = 1'b0; ld_issue = 1'b0; ld_done = 1'b0;
    DA = 5'd0; ld_dest = 5'd0; D_data = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; idle(); AA = 5'd5; BA = 5'd7;
    step();
    expect_out("reset", 32'h0, 32'h0, 1'b0, 6'd0);
    step();
    rst_n = 1'b1;

    RW = 1'b1; DA = 5'd5; D_data = 32'hDEADBEEF; AA = 5'd0; BA = 5'd0;
    expect_out("wr5", 32'h0, 32'h0, 1'b0, 6'd0);
    step(); idle(); AA = 5'd5; BA = 5'd0;
    expect_out("rd5", 32'hDEADBEEF, 32'h0, 1'b0, 6'd0);
    step();
    RW = 1'b1; DA = 5'd0; D_data = 32'hFFFFFFFF; AA = 5'd0; BA = 5'd5;
    expect_out("wr0", 32'h0, 32'hDEADBEEF, 1'b0, 6'd0);
    step(); idle();
    expect_out("rd0", 32'h0, 32'hDEADBEEF, 1'b0, 6'd0);

    // Load to r7 then its write-back
    step(); ld_issue = 1'b1; ld_dest = 5'd7; AA = 5'd7; BA = 5'd7;
    expect_out("ld7_issue", 32'h0, 32'h0, 1'b0, 6'd0);
    step(); idle(); AA = 5'd0;
    expect_out("ld7_pend", 32'h0, 32'h0, 1'b1, 6'd1);
    step(); RW = 1'b1; ld_done = 1'b1; DA = 5'd7; D_data = 32'h1234;
    expect_out("ld7_done", 32'h0, BYP ? 32'h1234 : 32'h0, !BYP, 6'd1);
    step(); idle();
    expect_out("ld7_clear", 32'h0, 32'h1234, 1'b0, 6'd0);

    // Set wins over clear on r9
    step(); ld_issue = 1'b1; ld_dest = 5'd9; BA = 5'd0;
    step(); AA = 5'd9; RW = 1'b1; ld_done = 1'b1; DA = 5'd9; D_data = 32'h55;
    expect_out("r9_setclr", BYP ? 32'h55 : 32'h0, 32'h0, !BYP, 6'd1);
    step(); idle();
    expect_out("r9_setwins", 32'h55, 32'h0, 1'b1, 6'd1);
    // Re-issue to pending r9, plus ld_done without RW
    step(); ld_issue = 1'b1; ld_dest = 5'd9; ld_done = 1'b1; DA = 5'd9;
    step(); idle();
    RW = 1'b1; DA = 5'd9; D_data = 32'h66;
    expect_out("r9_plainwr", BYP ? 32'h66 : 32'h55, 32'h0, 1'b1, 6'd1);
    step(); idle();
    expect_out("r9_stillpend", 32'h66, 32'h0, 1'b1, 6'd1);
    step(); RW = 1'b1; ld_done = 1'b1; DA = 5'd9; D_data = 32'h77; AA = 5'd0;
    step(); idle(); AA = 5'd9; ld_issue = 1'b1; ld_dest = 5'd0;
    expect_out("r9_cleared", 32'h77, 32'h0, 1'b0, 6'd0);

    // Forwarding behaviour on r3
    step(); idle(); RW = 1'b1; DA = 5'd3; D_data = 32'h11;
    expect_out("ld_r0_ignored", 32'h77, 32'h0, 1'b0, 6'd0);
    step(); RW = 1'b1; DA = 5'd3; D_data = 32'hA5A5A5A5; AA = 5'd3; BA = 5'd3;
    expect_out("bypass", BYP ? 32'hA5A5A5A5 : 32'h11, BYP ? 32'hA5A5A5A5 : 32'h11, 1'b0, 6'd0);
    step(); idle();
    expect_out("after_wr3", 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 6'd0);

    // Pend r4, r6 then asynchronous reset mid-cycle
    step(); ld_issue = 1'b1; ld_dest = 5'd4;
    step(); ld_issue = 1'b1; ld_dest = 5'd6;
    step(); idle(); AA = 5'd4; BA = 5'd6;
    expect_out("pend46", 32'h0, 32'h0, 1'b1, 6'd2);
    step(); AA = 5'd5; BA = 5'd3;
    #2 rst_n = 1'b0;
    expect_out("mid_reset", 32'h0, 32'h0, 1'b0, 6'd0);
    step(); rst_n = 1'b1;
    RW = 1'b1; ld_done = 1'b1; DA = 5'd4; D_data = 32'h99; AA = 5'd0; BA = 5'd0;
    step(); idle(); AA = 5'd4; BA = 5'd6;
    expect_out("late_done", 32'h99, 32'h0, 1'b0, 6'd0);

    step(); step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
